// File: rtl/out_mem_ctrl_pkg.sv
// Shared definitions for the out-memory controller: default geometry and FSM state encodings.
// Default geometry can be overridden by defining OUT_MEM_NUM_ROWS / OUT_MEM_NUM_BITS.
`ifndef OUT_MEM_NUM_ROWS
`define OUT_MEM_NUM_ROWS 64
`endif
`ifndef OUT_MEM_NUM_BITS
`define OUT_MEM_NUM_BITS 8
`endif

package out_mem_ctrl_pkg;

  localparam int unsigned OUT_MEM_NUM_ROWS_DEF = `OUT_MEM_NUM_ROWS;
  localparam int unsigned OUT_MEM_NUM_BITS_DEF = `OUT_MEM_NUM_BITS;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_ACC_RD    = 3'd2,
    ST_ACC_CAP   = 3'd3,
    ST_ACC_WR    = 3'd4,
    ST_DRAIN_RD  = 3'd5,
    ST_DRAIN_OUT = 3'd6
  } state_t;

endpackage

// File: rtl/out_mem_acc_alu.sv
// Accumulate adder for the out-memory controller: unsigned row value + addend.
// Ports: i_a (row value), i_b (addend), o_sum_c (combinational sum).
// Macro OUT_MEM_CTRL_SAT_EN: when defined the sum saturates at all-ones, otherwise it wraps.
module out_mem_acc_alu #(
  parameter int unsigned NUM_BITS = 8
) (
  input  logic [NUM_BITS-1:0] i_a,
  input  logic [NUM_BITS-1:0] i_b,
  output logic [NUM_BITS-1:0] o_sum_c
);

`ifdef OUT_MEM_CTRL_SAT_EN
  localparam int unsigned WW = NUM_BITS + 1;

  logic [WW-1:0] sum_wide;

  // Carry-out selects the saturated value.
  always_comb begin
    sum_wide = WW'(i_a) + WW'(i_b);
    o_sum_c  = sum_wide[NUM_BITS] ? '1 : sum_wide[NUM_BITS-1:0];
  end
`else
  // Carry is dropped: modulo 2^NUM_BITS.
  always_comb begin
    o_sum_c = i_a + i_b;
  end
`endif

endmodule

// File: rtl/out_mem_ctrl.sv
// Out-memory controller for one PE: sequences the partial-sum memory pins and arbitrates
// clear (highest), drain (full readout) and accumulate (read-modify-write add) requests.
// Ports: w_clock/w_reset_n (async active-low); w_clear; w_acc_* accumulate handshake;
// w_drain_* drain stream; w_busy; w_mem_* memory pins.
// Macro OUT_MEM_CTRL_SAT_EN selects a saturating accumulate (see out_mem_acc_alu).
module out_mem_ctrl
  import out_mem_ctrl_pkg::*;
#(
  parameter int unsigned OUT_MEM_NUM_ROWS   = OUT_MEM_NUM_ROWS_DEF,
  parameter int unsigned OUT_MEM_ADDR_WIDTH = $clog2(OUT_MEM_NUM_ROWS),
  parameter int unsigned OUT_MEM_NUM_BITS   = OUT_MEM_NUM_BITS_DEF
) (
  input  logic                          w_clock,
  input  logic                          w_reset_n,
  input  logic                          w_clear,
  input  logic                          w_acc_valid,
  output logic                          w_acc_ready,
  input  logic [OUT_MEM_ADDR_WIDTH-1:0] w_acc_addr,
  input  logic [OUT_MEM_NUM_BITS-1:0]   w_acc_data,
  input  logic                          w_drain_start,
  output logic                          w_drain_valid,
  input  logic                          w_drain_ready,
  output logic [OUT_MEM_ADDR_WIDTH-1:0] w_drain_addr,
  output logic [OUT_MEM_NUM_BITS-1:0]   w_drain_data,
  output logic                          w_drain_done,
  output logic                          w_busy,
  output logic                          w_mem_ready,
  output logic                          w_mem_rw,
  output logic [OUT_MEM_ADDR_WIDTH-1:0] w_mem_address,
  output logic [OUT_MEM_NUM_BITS-1:0]   w_mem_data_in,
  input  logic [OUT_MEM_NUM_BITS-1:0]   w_mem_data_out
);

  localparam int unsigned AW = OUT_MEM_ADDR_WIDTH;
  localparam int unsigned DW = OUT_MEM_NUM_BITS;
  localparam logic [AW-1:0] LAST_ROW = AW'(OUT_MEM_NUM_ROWS - 1);

  state_t        state_q, state_d;
  logic          pend_q, pend_d;
  logic [AW-1:0] acc_addr_q, acc_addr_d;
  logic [DW-1:0] acc_data_q, acc_data_d;
  logic [AW-1:0] row_q, row_d;

  logic          mem_ready_q, mem_ready_d;
  logic          mem_rw_q, mem_rw_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_din_q, mem_din_d;
  logic          drain_valid_q, drain_valid_d;
  logic [AW-1:0] drain_addr_q, drain_addr_d;
  logic          drain_done_q, drain_done_d;
  logic          busy_q, busy_d;

  logic [DW-1:0] sum_c;
  logic          acc_ready_c;

  out_mem_acc_alu #(
    .NUM_BITS(DW)
  ) u_alu (
    .i_a    (w_mem_data_out),
    .i_b    (acc_data_q),
    .o_sum_c(sum_c)
  );

  // Accept handshake must see this cycle's competing requests, so it stays combinational.
  assign acc_ready_c = w_reset_n && (state_q == ST_IDLE) && !w_clear && !pend_q && !w_drain_start;

  // Next state, request latching and registered output decode from the next state.
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    acc_addr_d   = acc_addr_q;
    acc_data_d   = acc_data_q;
    row_d        = row_q;
    drain_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pend_q || w_clear) begin
          state_d = ST_CLEAR;
        end else if (w_drain_start) begin
          state_d = ST_DRAIN_RD;
          row_d   = '0;
        end else if (w_acc_valid) begin
          acc_addr_d = w_acc_addr;
          acc_data_d = w_acc_data;
          state_d    = ST_ACC_RD;
        end
      end
      ST_CLEAR: begin
        pend_d  = 1'b0;
        state_d = ST_IDLE;
      end
      ST_ACC_RD:   state_d = ST_ACC_CAP;
      ST_ACC_CAP:  state_d = ST_ACC_WR;
      ST_ACC_WR:   state_d = ST_IDLE;
      ST_DRAIN_RD: state_d = ST_DRAIN_OUT;
      ST_DRAIN_OUT: begin
        if (w_drain_ready) begin
          if (row_q == LAST_ROW) begin
            drain_done_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            row_d   = row_q + AW'(1);
            state_d = ST_DRAIN_RD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A clear raised during CLEAR is satisfied by the zeroing already under way.
    if (w_clear && (state_q != ST_IDLE) && (state_q != ST_CLEAR)) begin
      pend_d = 1'b1;
    end

    mem_ready_d   = (state_d != ST_CLEAR);
    mem_rw_d      = (state_d == ST_ACC_WR);
    mem_din_d     = (state_d == ST_ACC_WR) ? sum_c : '0;
    drain_valid_d = (state_d == ST_DRAIN_OUT);
    drain_addr_d  = (state_d == ST_DRAIN_OUT) ? row_d : '0;
    busy_d        = (state_d != ST_IDLE);

    case (state_d)
      ST_ACC_RD, ST_ACC_CAP, ST_ACC_WR: mem_addr_d = acc_addr_d;
      ST_DRAIN_RD, ST_DRAIN_OUT:        mem_addr_d = row_d;
      default:                          mem_addr_d = '0;
    endcase
  end

  // State and output registers.
  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n) begin
      state_q       <= ST_IDLE;
      pend_q        <= 1'b0;
      acc_addr_q    <= '0;
      acc_data_q    <= '0;
      row_q         <= '0;
      mem_ready_q   <= 1'b0;
      mem_rw_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_din_q     <= '0;
      drain_valid_q <= 1'b0;
      drain_addr_q  <= '0;
      drain_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      acc_addr_q    <= acc_addr_d;
      acc_data_q    <= acc_data_d;
      row_q         <= row_d;
      mem_ready_q   <= mem_ready_d;
      mem_rw_q      <= mem_rw_d;
      mem_addr_q    <= mem_addr_d;
      mem_din_q     <= mem_din_d;
      drain_valid_q <= drain_valid_d;
      drain_addr_q  <= drain_addr_d;
      drain_done_q  <= drain_done_d;
      busy_q        <= busy_d;
    end
  end

  assign w_acc_ready   = acc_ready_c;
  assign w_drain_valid = drain_valid_q;
  assign w_drain_addr  = drain_addr_q;
  // Memory holds the row on its output while the address is held, so the beat is stable on stall.
  assign w_drain_data  = drain_valid_q ? w_mem_data_out : '0;
  assign w_drain_done  = drain_done_q;
  assign w_busy        = busy_q;
  assign w_mem_ready   = mem_ready_q;
  assign w_mem_rw      = mem_rw_q;
  assign w_mem_address = mem_addr_q;
  assign w_mem_data_in = mem_din_q;

endmodule

// File: tb/tb_out_mem_ctrl.sv
// Bench for out_mem_ctrl with a behavioural out-memory and a reference row model.
module tb_out_mem_ctrl;

  logic       clk = 1'b0;
  logic       w_reset_n;
  logic       w_clear;
  logic       w_acc_valid;
  logic       w_acc_ready;
  logic [5:0] w_acc_addr;
  logic [7:0] w_acc_data;
  logic       w_drain_start;
  logic       w_drain_valid;
  logic       w_drain_ready;
  logic [5:0] w_drain_addr;
  logic [7:0] w_drain_data;
  logic       w_drain_done;
  logic       w_busy;
  logic       w_mem_ready;
  logic       w_mem_rw;
  logic [5:0] w_mem_address;
  logic [7:0] w_mem_data_in;
  logic [7:0] w_mem_data_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  out_mem_ctrl dut (
    .w_clock       (clk),
    .w_reset_n     (w_reset_n),
    .w_clear       (w_clear),
    .w_acc_valid   (w_acc_valid),
    .w_acc_ready   (w_acc_ready),
    .w_acc_addr    (w_acc_addr),
    .w_acc_data    (w_acc_data),
    .w_drain_start (w_drain_start),
    .w_drain_valid (w_drain_valid),
    .w_drain_ready (w_drain_ready),
    .w_drain_addr  (w_drain_addr),
    .w_drain_data  (w_drain_data),
    .w_drain_done  (w_drain_done),
    .w_busy        (w_busy),
    .w_mem_ready   (w_mem_ready),
    .w_mem_rw      (w_mem_rw),
    .w_mem_address (w_mem_address),
    .w_mem_data_in (w_mem_data_in),
    .w_mem_data_out(w_mem_data_out)
  );

  // Behavioural out-memory: ready=0 zeroes, rw=1 writes, rw=0 registers the row.
  logic [7:0] mem [64];
  logic [5:0] mem_areg;
  always @(posedge clk) begin
    if (!w_mem_ready) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'd0;
    end else if (w_mem_rw) begin
      mem[w_mem_address] <= w_mem_data_in;
    end else begin
      mem_areg <= w_mem_address;
    end
  end
  assign w_mem_data_out = (w_mem_ready && !w_mem_rw) ? mem[mem_areg] : 8'd0;

  // Reference contents and accumulate model.
  logic [7:0] ref_mem [64];

  function automatic logic [7:0] model_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef OUT_MEM_CTRL_SAT_EN
    if (s[8]) return 8'hFF;
`endif
    return s[7:0];
  endfunction

`ifdef OUT_MEM_CTRL_SAT_EN
  localparam logic [7:0] OVF_7  = 8'd255;
  localparam logic [7:0] OVF_0  = 8'd255;
  localparam logic [7:0] OVF_63 = 8'd255;
`else
  localparam logic [7:0] OVF_7  = 8'd4;
  localparam logic [7:0] OVF_0  = 8'd0;
  localparam logic [7:0] OVF_63 = 8'd0;
`endif

  typedef struct {
    logic [5:0] addr;
    logic [7:0] data;
    logic [7:0] exp_row;
  } acc_vec_t;
  acc_vec_t vecs [8];

  typedef struct packed {
    logic [5:0] addr;
    logic [7:0] data;
  } beat_t;
  beat_t exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ref_clear();
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'd0;
  endtask

  // One accumulate; optionally checks write latency, address and written sum.
  task automatic do_acc(input logic [5:0] a, input logic [7:0] d, input bit chk_en,
                        input logic [7:0] exp_row);
    int n;
    w_acc_valid = 1'b1;
    w_acc_addr  = a;
    w_acc_data  = d;
    #1;
    n = 0;
    while (!w_acc_ready && n < 20) begin
      tick();
      n++;
    end
    if (!w_acc_ready) begin
      chk("acc_accept_timeout", {31'd0, w_acc_ready}, 32'd1);
      w_acc_valid = 1'b0;
      return;
    end
    ref_mem[a] = model_add(ref_mem[a], d);
    tick();
    w_acc_valid = 1'b0;
    n = 1;
    while (!w_mem_rw && n < 8) begin
      tick();
      n++;
    end
    if (chk_en) begin
      chk("acc_wr_latency", n, 3);
      chk("acc_wr_addr", {26'd0, w_mem_address}, {26'd0, a});
      chk("acc_wr_data", {24'd0, w_mem_data_in}, {24'd0, exp_row});
    end
    tick();
  endtask

  // Full drain checked against the reference contents captured at start.
  task automatic do_drain(input bit stall, input int clear_beat, input bit exp_clear_next);
    int   beats, vcnt, cyc, done_hi;
    bit   prev_stall;
    logic [5:0] prev_addr;
    logic [7:0] prev_data;
    beat_t b;
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back('{addr: 6'(i), data: ref_mem[i]});
    beats = 0; vcnt = 0; cyc = 0; done_hi = 0; prev_stall = 0;
    prev_addr = '0; prev_data = '0;
    w_drain_start = 1'b1;
    tick();
    w_drain_start = 1'b0;
    while (beats < 64 && cyc < 1000) begin
      w_clear = 1'b0;
      if (w_drain_done) done_hi++;
      if (w_drain_valid) begin
        if (prev_stall) begin
          chk("drain_stall_addr", {26'd0, w_drain_addr}, {26'd0, prev_addr});
          chk("drain_stall_data", {24'd0, w_drain_data}, {24'd0, prev_data});
        end
        w_drain_ready = stall ? (vcnt % 2 == 1) : 1'b1;
        vcnt++;
        if (w_drain_ready) begin
          b = exp_q.pop_front();
          chk("drain_addr", {26'd0, w_drain_addr}, {26'd0, b.addr});
          chk("drain_data", {24'd0, w_drain_data}, {24'd0, b.data});
          if (beats == clear_beat) w_clear = 1'b1;
          beats++;
          prev_stall = 0;
        end else begin
          prev_stall = 1;
          prev_addr  = w_drain_addr;
          prev_data  = w_drain_data;
        end
      end else begin
        w_drain_ready = 1'b0;
      end
      tick();
      cyc++;
    end
    w_clear       = 1'b0;
    w_drain_ready = 1'b0;
    chk("drain_beats", beats, 64);
    chk("drain_early_done", done_hi, 0);
    chk("drain_done_pulse", {31'd0, w_drain_done}, 32'd1);
    chk("drain_valid_idle", {31'd0, w_drain_valid}, 32'd0);
    chk("drain_addr_idle", {26'd0, w_drain_addr}, 32'd0);
    chk("drain_data_idle", {24'd0, w_drain_data}, 32'd0);
    tick();
    chk("drain_done_low", {31'd0, w_drain_done}, 32'd0);
    chk("post_drain_mem_ready", {31'd0, w_mem_ready}, {31'd0, !exp_clear_next});
    chk("post_drain_busy", {31'd0, w_busy}, {31'd0, exp_clear_next});
    if (exp_clear_next) begin
      ref_clear();
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{6'd5,  8'd3,   8'd9};
    vecs[1] = '{6'd7,  8'd250, 8'd250};
    vecs[2] = '{6'd7,  8'd10,  OVF_7};
    vecs[3] = '{6'd0,  8'd255, 8'd255};
    vecs[4] = '{6'd0,  8'd1,   OVF_0};
    vecs[5] = '{6'd63, 8'd128, 8'd128};
    vecs[6] = '{6'd63, 8'd127, 8'd255};
    vecs[7] = '{6'd63, 8'd1,   OVF_63};

    w_reset_n = 1'b0; w_clear = 1'b0; w_acc_valid = 1'b0; w_acc_addr = '0;
    w_acc_data = '0; w_drain_start = 1'b0; w_drain_ready = 1'b0;
    ref_clear();

    // Reset state.
    tick(); tick();
    chk("rst_mem_ready", {31'd0, w_mem_ready}, 32'd0);
    chk("rst_busy", {31'd0, w_busy}, 32'd0);
    chk("rst_acc_ready", {31'd0, w_acc_ready}, 32'd0);
    chk("rst_rw", {31'd0, w_mem_rw}, 32'd0);
    w_reset_n = 1'b1;
    tick();
    chk("idle_mem_ready", {31'd0, w_mem_ready}, 32'd1);
    chk("idle_addr", {26'd0, w_mem_address}, 32'd0);
    chk("idle_busy", {31'd0, w_busy}, 32'd0);
    chk("idle_acc_ready", {31'd0, w_acc_ready}, 32'd1);

    // Test 1: clear pulse then drain of zeros.
    w_clear = 1'b1;
    #1;
    chk("t1_acc_ready_blocked", {31'd0, w_acc_ready}, 32'd0);
    tick();
    w_clear = 1'b0;
    chk("t1_clear_mem_ready", {31'd0, w_mem_ready}, 32'd0);
    chk("t1_clear_busy", {31'd0, w_busy}, 32'd1);
    tick();
    chk("t1_after_mem_ready", {31'd0, w_mem_ready}, 32'd1);
    chk("t1_after_busy", {31'd0, w_busy}, 32'd0);
    ref_clear();
    do_drain(1'b0, -1, 1'b0);

    // Test 2: back-to-back accumulates to row 5.
    w_acc_valid = 1'b1; w_acc_addr = 6'd5; w_acc_data = 8'd3;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("t2_accept", {31'd0, w_acc_ready}, 32'd1);
      ref_mem[5] = model_add(ref_mem[5], 8'd3);
      tick();
      chk("t2_rd_ready", {31'd0, w_acc_ready}, 32'd0);
      chk("t2_rd_rw", {31'd0, w_mem_rw}, 32'd0);
      chk("t2_rd_addr", {26'd0, w_mem_address}, 32'd5);
      tick();
      chk("t2_cap_ready", {31'd0, w_acc_ready}, 32'd0);
      chk("t2_cap_rw", {31'd0, w_mem_rw}, 32'd0);
      tick();
      chk("t2_wr_ready", {31'd0, w_acc_ready}, 32'd0);
      chk("t2_wr_rw", {31'd0, w_mem_rw}, 32'd1);
      chk("t2_wr_data", {24'd0, w_mem_data_in}, 32'(3 * (k + 1)));
      if (k == 1) w_acc_valid = 1'b0;
      tick();
    end
    chk("t2_idle_din", {24'd0, w_mem_data_in}, 32'd0);

    // Test 3: table of accumulates including overflow boundaries.
    foreach (vecs[i]) do_acc(vecs[i].addr, vecs[i].data, 1'b1, vecs[i].exp_row);
    do_drain(1'b1, -1, 1'b0);

    // Test 4: rows i=i, drain with every beat stalled once.
    w_clear = 1'b1; tick(); w_clear = 1'b0; tick();
    ref_clear();
    for (int i = 0; i < 64; i++) do_acc(6'(i), 8'(i), 1'b0, 8'd0);
    do_drain(1'b1, -1, 1'b0);

    // Test 5: clear raised at beat 10 is deferred until the drain finishes.
    do_drain(1'b0, 10, 1'b1);
    do_drain(1'b0, -1, 1'b0);

    // Test 6: reset during ACC_CAP aborts the write.
    do_acc(6'd3, 8'd9, 1'b1, 8'd9);
    w_acc_valid = 1'b1; w_acc_addr = 6'd3; w_acc_data = 8'd1;
    #1;
    chk("t6_accept", {31'd0, w_acc_ready}, 32'd1);
    tick();
    w_acc_valid = 1'b0;
    tick();
    chk("t6_cap_busy", {31'd0, w_busy}, 32'd1);
    chk("t6_cap_addr", {26'd0, w_mem_address}, 32'd3);
    w_reset_n = 1'b0;
    #1;
    chk("t6_rst_rw", {31'd0, w_mem_rw}, 32'd0);
    chk("t6_rst_mem_ready", {31'd0, w_mem_ready}, 32'd0);
    chk("t6_rst_busy", {31'd0, w_busy}, 32'd0);
    chk("t6_rst_addr", {26'd0, w_mem_address}, 32'd0);
    chk("t6_rst_din", {24'd0, w_mem_data_in}, 32'd0);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("t6_hold_rw", {31'd0, w_mem_rw}, 32'd0);
    end
    ref_clear();
    w_reset_n = 1'b1;
    tick();
    chk("t6_release_mem_ready", {31'd0, w_mem_ready}, 32'd1);
    chk("t6_release_busy", {31'd0, w_busy}, 32'd0);
    do_drain(1'b0, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
